sseg_scan_decoder: RTL

//  Receive side of the multiplexed 4-digit seven-segment interface (seg/dp/an, all active-low).

---
 rtl/sseg_pkg.sv | 36 +++
 rtl/sseg_stable_filter.sv | 98 +++++++++
 rtl/sseg_scan_decoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
// Contents: seg_t, NUM_DIGITS, SEG_BLANK, GLYPH table (active-low, index = hex value),
// state_t for the stability FSM and seg_to_hex(), which maps a segment pattern to its nibble.
package sseg_pkg;

    typedef logic [6:0] seg_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam seg_t        SEG_BLANK  = 7'h7F;

    // Active-low glyphs {g,f,e,d,c,b,a}; GLYPH[h] is the pattern for hex value h.
    localparam seg_t [15:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        WAIT_STABLE,
        CAPTURED
    } state_t;

    // Returns the hex value of a legal glyph; valid is low for any other pattern.
    function automatic logic [3:0] seg_to_hex(input seg_t s, output logic valid);
        logic [3:0] value;
        value = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (GLYPH[i] == s) begin
                value = 4'(i);
                valid = 1'b1;
            end
        end
        return value;
    endfunction

endpackage

// File: rtl/sseg_stable_filter.sv
// Input synchroniser and stability filter for the scanned display pins.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   an, seg, dp     raw active-low display pins
//   capture         one-cycle strobe: the sample has been stable for STABLE_CYCLES samples
//   an_stable, seg_stable, dp_stable   current synchronised sample (valid with capture)
// Parameters: STABLE_CYCLES (1..255), SYNC_STAGES (2..3).
module sseg_stable_filter
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] an,
    input  seg_t       seg,
    input  logic       dp,
    output logic       capture,
    output logic [3:0] an_stable,
    output seg_t       seg_stable,
    output logic       dp_stable
);

    localparam int unsigned W        = 12;
    localparam logic [7:0]  CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  sample;
    logic [W-1:0]                  incoming;
    logic                          changed;
    logic [7:0]                    cnt;
    state_t                        state;
    state_t                        state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= {an, seg, dp};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sample   = sync_q[SYNC_STAGES-1];
    assign incoming = sync_q[SYNC_STAGES-2];

    // The change test looks at the value about to enter the sample stage, so the
    // counter restarts in the same edge the new sample appears. This keeps the
    // pin-to-capture latency at SYNC_STAGES + STABLE_CYCLES clocks.
    assign changed = (incoming != sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (changed) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_STABLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        if (changed) begin
            state_next = WAIT_STABLE;
        end else begin
            case (state)
                WAIT_STABLE: begin
                    if (cnt == CNT_LAST) begin
                        capture    = 1'b1;
                        state_next = CAPTURED;
                    end
                end
                CAPTURED: begin
                    state_next = CAPTURED;
                end
                default: begin
                    state_next = WAIT_STABLE;
                end
            endcase
        end
    end

    assign {an_stable, seg_stable, dp_stable} = sample;

endmodule

// File: rtl/sseg_scan_decoder.sv
// Receive side of a multiplexed 4-digit seven-segment display (all pins active-low).
// Samples the scanned pins, waits for each digit slot to settle and decodes it to a nibble.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   seg, dp, an   segment {g..a}, decimal point and anode pins
//   digits        decoded nibbles, digit i at [4i+3:4i]
//   digit_valid   digit i last captured as a legal glyph
//   dp_out        decimal point lit for digit i at its last capture
//   frame_done    pulse once all four digits have been captured since the previous pulse
//   err           pulse on an illegal capture (bad glyph or several anodes active)
//   err_count     saturating error count, present only when SSEG_DEC_ERRCNT_EN is defined
// Optional feature macro: SSEG_DEC_ERRCNT_EN.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic        dp,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  dp_out,
    output logic        frame_done,
    output logic        err
`ifdef SSEG_DEC_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    logic       capture;
    logic [3:0] an_s;
    seg_t       seg_s;
    logic       dp_s;

    sseg_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .capture   (capture),
        .an_stable (an_s),
        .seg_stable(seg_s),
        .dp_stable (dp_s)
    );

    logic [3:0]  seen;
    logic [3:0]  seen_next;
    logic [15:0] digits_next;
    logic [3:0]  valid_next;
    logic [3:0]  dp_next;
    logic        err_next;
    logic        frame_next;
    logic [2:0]  zeros;
    logic [1:0]  idx;
    logic [3:0]  hex;
    logic        glyph_ok;

    always_comb begin
        zeros       = '0;
        idx         = '0;
        hex         = seg_to_hex(seg_s, glyph_ok);
        seen_next   = seen;
        digits_next = digits;
        valid_next  = digit_valid;
        dp_next     = dp_out;
        err_next    = 1'b0;
        frame_next  = 1'b0;

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                zeros = zeros + 3'd1;
                idx   = 2'(i);
            end
        end

        if (capture) begin
            if (zeros == 3'd1) begin
                seen_next[idx] = 1'b1;
                if (glyph_ok) begin
                    digits_next[{idx, 2'b00} +: 4] = hex;
                    valid_next[idx]                = 1'b1;
                    dp_next[idx]                   = ~dp_s;
                end else begin
                    valid_next[idx] = 1'b0;
                    err_next        = (seg_s != SEG_BLANK);
                end
            end else if (zeros >= 3'd2) begin
                err_next = 1'b1;
            end
        end

        // Frame completion clears the mask in the same edge, so a capture during
        // the frame_done cycle starts the next frame.
        if (seen_next == '1) begin
            frame_next = 1'b1;
            seen_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            digit_valid <= '0;
            dp_out      <= '0;
            seen        <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            digits      <= digits_next;
            digit_valid <= valid_next;
            dp_out      <= dp_next;
            seen        <= seen_next;
            frame_done  <= frame_next;
            err         <= err_next;
        end
    end

`ifdef SSEG_DEC_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_next && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
